// File: rtl/ime_mv_ram_ctrl.sv
// Port controller for the 64x13 IME motion-vector RAM: clear sweep after reset/clr_i,
// then round-robin sharing of the single RAM port between the IME writer and FME reader.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | sweeping INIT_VAL into every entry, requests held off
// ST_RUN  | arbitrating writer/reader onto the RAM port
module ime_mv_ram_ctrl #(
  parameter int unsigned   AW       = 6,
  parameter int unsigned   DW       = 13,
  parameter logic [DW-1:0] INIT_VAL = 13'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          init_done_o,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_adr_i,
  input  logic [DW-1:0] wr_dat_i,
  output logic          wr_ack_o,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_adr_i,
  output logic          rd_ack_o,
  output logic          rd_val_o,
  output logic [DW-1:0] rd_dat_o,
  output logic [AW-1:0] ram_adr_o,
  output logic          ram_wr_ena_o,
  output logic          ram_rd_ena_o,
  output logic [DW-1:0] ram_wr_dat_o,
  input  logic [DW-1:0] ram_rd_dat_i
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] init_cnt;
  logic [AW-1:0] adr_q;
  logic          last_gnt_rd;
  logic          gnt_wr;
  logic          gnt_rd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (!clr_i && (init_cnt == CNT_LAST)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr_i) begin
          state_nxt = ST_INIT;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Output logic: arbitration and RAM port drive; reset gates everything inactive
  always_comb begin
    gnt_wr       = 1'b0;
    gnt_rd       = 1'b0;
    ram_adr_o    = adr_q;
    ram_wr_ena_o = 1'b1;
    ram_rd_ena_o = 1'b1;
    ram_wr_dat_o = (state == ST_INIT) ? INIT_VAL : wr_dat_i;
    if (rst_n) begin
      if (state == ST_INIT) begin
        ram_wr_ena_o = 1'b0;
        ram_adr_o    = init_cnt;
      end else begin
        // On conflict the side that did not win last time is served
        if (wr_req_i && (!rd_req_i || last_gnt_rd)) begin
          gnt_wr = 1'b1;
        end else if (rd_req_i) begin
          gnt_rd = 1'b1;
        end
        if (gnt_wr) begin
          ram_wr_ena_o = 1'b0;
          ram_adr_o    = wr_adr_i;
        end else if (gnt_rd) begin
          ram_rd_ena_o = 1'b0;
          ram_adr_o    = rd_adr_i;
        end
      end
    end
  end

  assign wr_ack_o = gnt_wr;
  assign rd_ack_o = gnt_rd;
  assign rd_dat_o = ram_rd_dat_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= clr_i ? '0 : init_cnt + 1'b1;
    end else if (clr_i) begin
      init_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_rd <= 1'b1;
      rd_val_o    <= 1'b0;
      init_done_o <= 1'b0;
      adr_q       <= '0;
    end else begin
      if (gnt_wr) begin
        last_gnt_rd <= 1'b0;
      end else if (gnt_rd) begin
        last_gnt_rd <= 1'b1;
      end
      rd_val_o    <= gnt_rd;
      init_done_o <= (state_nxt == ST_RUN);
      adr_q       <= ram_adr_o;
    end
  end

endmodule

// File: tb/tb_ime_mv_ram_ctrl.sv
// Directed bench for ime_mv_ram_ctrl with a 1-cycle-latency behavioural RAM attached.
module tb_ime_mv_ram_ctrl;
  localparam int AW = 6;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          init_done;
  logic          wr_req;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_dat;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_adr;
  logic          rd_ack;
  logic          rd_val;
  logic [DW-1:0] rd_dat;
  logic [AW-1:0] ram_adr;
  logic          ram_wr_ena;
  logic          ram_rd_ena;
  logic [DW-1:0] ram_wr_dat;
  logic [DW-1:0] ram_rd_dat = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ime_mv_ram_ctrl #(.AW(AW), .DW(DW), .INIT_VAL(13'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .init_done_o (init_done),
    .wr_req_i    (wr_req),
    .wr_adr_i    (wr_adr),
    .wr_dat_i    (wr_dat),
    .wr_ack_o    (wr_ack),
    .rd_req_i    (rd_req),
    .rd_adr_i    (rd_adr),
    .rd_ack_o    (rd_ack),
    .rd_val_o    (rd_val),
    .rd_dat_o    (rd_dat),
    .ram_adr_o   (ram_adr),
    .ram_wr_ena_o(ram_wr_ena),
    .ram_rd_ena_o(ram_rd_ena),
    .ram_wr_dat_o(ram_wr_dat),
    .ram_rd_dat_i(ram_rd_dat)
  );

  // Behavioural RAM, preloaded with junk so the clear sweep is observable
  logic [DW-1:0] mem [64] = '{default: 13'h1555};
  always @(posedge clk) begin
    if (!ram_wr_ena) mem[ram_adr] <= ram_wr_dat;
    if (!ram_rd_ena) ram_rd_dat <= mem[ram_adr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    wr_req = 1'b1;
    wr_adr = 6'd5;
    wr_dat = 13'h1ABC;
    rd_req = 1'b0;
    rd_adr = '0;
    #2;
    chk("rst_wr_ena", 32'(ram_wr_ena), 32'd1);
    chk("rst_rd_ena", 32'(ram_rd_ena), 32'd1);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rd_val", 32'(rd_val), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // post-reset sweep with writer already requesting
    for (int c = 0; c < 64; c++) begin
      settle();
      chk("clr_adr", 32'(ram_adr), 32'(c));
      chk("clr_wr_ena", 32'(ram_wr_ena), 32'd0);
      chk("clr_rd_ena", 32'(ram_rd_ena), 32'd1);
      chk("clr_dat", 32'(ram_wr_dat), 32'd0);
      chk("clr_wr_ack", 32'(wr_ack), 32'd0);
      chk("clr_init_done", 32'(init_done), 32'd0);
      tick();
    end
    settle();
    chk("c65_init_done", 32'(init_done), 32'd1);
    chk("c65_wr_ack", 32'(wr_ack), 32'd1);
    chk("c65_adr", 32'(ram_adr), 32'd5);
    chk("c65_wr_dat", 32'(ram_wr_dat), 32'h1ABC);
    tick();

    // single read back, then a cleared entry
    wr_req = 1'b0;
    rd_req = 1'b1;
    rd_adr = 6'd5;
    settle();
    chk("rd5_ack", 32'(rd_ack), 32'd1);
    chk("rd5_rd_ena", 32'(ram_rd_ena), 32'd0);
    chk("rd5_adr", 32'(ram_adr), 32'd5);
    chk("rd5_val_early", 32'(rd_val), 32'd0);
    tick();
    rd_adr = 6'd6;
    settle();
    chk("rd5_val", 32'(rd_val), 32'd1);
    chk("rd5_dat", 32'(rd_dat), 32'h1ABC);
    chk("rd6_ack", 32'(rd_ack), 32'd1);
    tick();
    rd_req = 1'b0;
    settle();
    chk("rd6_val", 32'(rd_val), 32'd1);
    chk("rd6_dat", 32'(rd_dat), 32'd0);
    chk("idle_ena", 32'({ram_wr_ena, ram_rd_ena}), 32'd3);
    tick();
    settle();
    chk("idle_val", 32'(rd_val), 32'd0);
    chk("idle_adr_hold", 32'(ram_adr), 32'd6);
    tick();

    // conflict fairness: last grant was a read, so writer goes first
    wr_req = 1'b1;
    rd_req = 1'b1;
    wr_adr = 6'd20;
    wr_dat = 13'h0F0F;
    rd_adr = 6'd21;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("rr_wr_ack", 32'(wr_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_rd_ack", 32'(rd_ack), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_enas", 32'({ram_wr_ena, ram_rd_ena}), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    rd_req = 1'b0;

    // back-to-back reads
    for (int k = 0; k < 3; k++) begin
      wr_adr = 6'(k);
      wr_dat = 13'(k + 1);
      settle();
      chk("b2b_wr_ack", 32'(wr_ack), 32'd1);
      tick();
    end
    wr_req = 1'b0;
    rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_adr = 6'(k);
      settle();
      chk("b2b_rd_ack", 32'(rd_ack), 32'd1);
      if (k > 0) begin
        chk("b2b_val", 32'(rd_val), 32'd1);
        chk("b2b_dat", 32'(rd_dat), 32'(k));
      end
      tick();
    end
    rd_req = 1'b0;
    settle();
    chk("b2b_val3", 32'(rd_val), 32'd1);
    chk("b2b_dat3", 32'(rd_dat), 32'd3);
    tick();
    settle();
    chk("b2b_val_end", 32'(rd_val), 32'd0);
    tick();

    // clear during operation with a read acked in the clr_i cycle
    wr_req = 1'b1;
    wr_adr = 6'd10;
    wr_dat = 13'd7;
    settle();
    chk("cl_wr_ack", 32'(wr_ack), 32'd1);
    tick();
    wr_req = 1'b0;
    rd_req = 1'b1;
    rd_adr = 6'd10;
    clr    = 1'b1;
    settle();
    chk("cl_rd_ack", 32'(rd_ack), 32'd1);
    chk("cl_init_done", 32'(init_done), 32'd1);
    tick();
    clr = 1'b0;
    for (int c = 0; c < 64; c++) begin
      settle();
      if (c == 0) begin
        chk("cl_rd_val", 32'(rd_val), 32'd1);
        chk("cl_rd_dat", 32'(rd_dat), 32'd7);
      end
      chk("cl2_adr", 32'(ram_adr), 32'(c));
      chk("cl2_wr_ena", 32'(ram_wr_ena), 32'd0);
      chk("cl2_rd_ack", 32'(rd_ack), 32'd0);
      chk("cl2_init_done", 32'(init_done), 32'd0);
      tick();
    end
    settle();
    chk("cl_run_done", 32'(init_done), 32'd1);
    chk("cl_run_ack", 32'(rd_ack), 32'd1);
    chk("cl_run_adr", 32'(ram_adr), 32'd10);
    tick();
    rd_req = 1'b0;
    settle();
    chk("cl_a10_val", 32'(rd_val), 32'd1);
    chk("cl_a10_dat", 32'(rd_dat), 32'd0);
    tick();

    // asynchronous reset while a read is in flight
    rd_req = 1'b1;
    rd_adr = 6'd3;
    settle();
    chk("ar_rd_ack", 32'(rd_ack), 32'd1);
    tick();
    #1;
    chk("ar_val_before", 32'(rd_val), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_val", 32'(rd_val), 32'd0);
    chk("ar_enas", 32'({ram_wr_ena, ram_rd_ena}), 32'd3);
    chk("ar_rd_ack_gated", 32'(rd_ack), 32'd0);
    chk("ar_init_done", 32'(init_done), 32'd0);
    rd_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("ar_sweep_adr0", 32'(ram_adr), 32'd0);
    chk("ar_sweep_wr_ena", 32'(ram_wr_ena), 32'd0);
    tick();
    settle();
    chk("ar_sweep_adr1", 32'(ram_adr), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
